// File: rtl/hpdcache_bank_xbar_buf.sv
// ---------------------------------------------------------------------------
// hpdcache_bank_xbar_buf
//
// Crossbar between N_REQS cache requesters and N_BANKS cache banks.
// Requests are steered to the bank named by each requester's bank id and
// arbitrated per bank, either round-robin or fixed lowest-index-first.
// Second-cycle signals (abort, late tag/PMA payload) follow the grant
// registered at acceptance. Bank responses are routed back by the
// requester id in the low SID_W bits of the payload, arbitrated per
// requester across banks, and buffered in a per-requester FIFO.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   core_req_*           per-requester request handshake, payload, bank id,
//                        and second-cycle abort / late payload
//   bank_req_*           per-bank request handshake and payload
//   bank_abort_o/late_o  per-bank second-cycle outputs
//   bank_rsp_*           per-bank response handshake and payload
//   core_rsp_*           per-requester response handshake and payload
//   err_sid_o            one-cycle pulse after a response with an
//                        out-of-range requester id is dropped
// ---------------------------------------------------------------------------
module hpdcache_bank_xbar_buf #(
  parameter int N_REQS    = 4,
  parameter int N_BANKS   = 2,
  parameter int REQ_W     = 64,
  parameter int LATE_W    = 40,
  parameter int RSP_W     = 72,
  parameter int SID_W     = 4,
  parameter int ARB_RR    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic [N_REQS-1:0]                                    core_req_valid_i,
  output logic [N_REQS-1:0]                                    core_req_ready_o,
  input  logic [N_REQS*REQ_W-1:0]                              core_req_i,
  input  logic [N_REQS*((N_BANKS > 1) ? $clog2(N_BANKS) : 1)-1:0] core_req_bid_i,
  input  logic [N_REQS-1:0]                                    core_req_abort_i,
  input  logic [N_REQS*LATE_W-1:0]                             core_req_late_i,
  output logic [N_BANKS-1:0]                                   bank_req_valid_o,
  input  logic [N_BANKS-1:0]                                   bank_req_ready_i,
  output logic [N_BANKS*REQ_W-1:0]                             bank_req_o,
  output logic [N_BANKS-1:0]                                   bank_abort_o,
  output logic [N_BANKS*LATE_W-1:0]                            bank_late_o,
  input  logic [N_BANKS-1:0]                                   bank_rsp_valid_i,
  output logic [N_BANKS-1:0]                                   bank_rsp_ready_o,
  input  logic [N_BANKS*RSP_W-1:0]                             bank_rsp_i,
  output logic [N_REQS-1:0]                                    core_rsp_valid_o,
  input  logic [N_REQS-1:0]                                    core_rsp_ready_i,
  output logic [N_REQS*RSP_W-1:0]                              core_rsp_o,
  output logic                                                 err_sid_o
);

  localparam int BID_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int RP_W  = (N_REQS > 1) ? $clog2(N_REQS) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // request side
  logic [N_REQS-1:0] req_match [N_BANKS];
  logic [N_REQS-1:0] req_hi    [N_BANKS];
  logic [N_REQS-1:0] req_sel   [N_BANKS];
  logic [N_REQS-1:0] gnt       [N_BANKS];
  logic [N_REQS-1:0] gnt_q     [N_BANKS];
  logic [RP_W-1:0]   rr_ptr_q  [N_BANKS];
  logic [RP_W-1:0]   rr_ptr_d  [N_BANKS];
  logic [N_BANKS-1:0] bank_acc;

  // response side
  logic [N_BANKS-1:0] rsp_match [N_REQS];
  logic [N_BANKS-1:0] rsp_hi    [N_REQS];
  logic [N_BANKS-1:0] rsp_sel   [N_REQS];
  logic [N_BANKS-1:0] rsp_gnt   [N_REQS];
  logic [BID_W-1:0]   rsp_ptr_q [N_REQS];
  logic [BID_W-1:0]   rsp_ptr_d [N_REQS];
  logic [N_BANKS-1:0] drop_gnt;
  logic [N_REQS-1:0]  full;
  logic [N_REQS-1:0]  push;
  logic [N_REQS-1:0]  pop;
  logic [RSP_W-1:0]   push_data [N_REQS];
  logic [RSP_W-1:0]   mem       [N_REQS][RSP_DEPTH];
  logic [PTR_W-1:0]   wptr_q    [N_REQS];
  logic [PTR_W-1:0]   rptr_q    [N_REQS];
  logic [CNT_W-1:0]   cnt_q     [N_REQS];
  logic               err_sid_q;

  // Per-bank request arbitration. Round-robin picks the lowest matching
  // requester at or above the pointer, falling back to the lowest overall;
  // with ARB_RR=0 the upper mask is empty so the lowest index always wins.
  always_comb begin
    bank_req_o       = '0;
    core_req_ready_o = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int r = 0; r < N_REQS; r++) begin
        req_match[b][r] = core_req_valid_i[r] &&
                          (int'(core_req_bid_i[r*BID_W +: BID_W]) == b);
        req_hi[b][r]    = req_match[b][r] && (ARB_RR != 0) &&
                          (r >= int'(rr_ptr_q[b]));
      end
      req_sel[b] = (|req_hi[b]) ? req_hi[b] : req_match[b];
      gnt[b] = '0;
      for (int r = N_REQS - 1; r >= 0; r--) begin
        if (req_sel[b][r]) gnt[b] = N_REQS'(1) << r;
      end
      rr_ptr_d[b] = rr_ptr_q[b];
      for (int r = 0; r < N_REQS; r++) begin
        if (gnt[b][r]) begin
          rr_ptr_d[b] = (r == N_REQS - 1) ? '0 : RP_W'(r + 1);
          bank_req_o[b*REQ_W +: REQ_W] = core_req_i[r*REQ_W +: REQ_W];
          if (bank_req_ready_i[b]) core_req_ready_o[r] = 1'b1;
        end
      end
      bank_req_valid_o[b] = |gnt[b];
      bank_acc[b]         = bank_req_valid_o[b] & bank_req_ready_i[b];
    end
  end

  // Second-cycle outputs follow the grant captured at acceptance; an idle
  // bank has gnt_q all-zero so abort and late stay low.
  always_comb begin
    bank_abort_o = '0;
    bank_late_o  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int r = 0; r < N_REQS; r++) begin
        if (gnt_q[b][r]) begin
          bank_abort_o[b] = core_req_abort_i[r];
          bank_late_o[b*LATE_W +: LATE_W] = core_req_late_i[r*LATE_W +: LATE_W];
        end
      end
    end
  end

  // Grant capture and round-robin pointer advance, only on accepted requests.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) begin
        gnt_q[b]    <= '0;
        rr_ptr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        gnt_q[b] <= bank_acc[b] ? gnt[b] : '0;
        if (bank_acc[b]) rr_ptr_q[b] <= rr_ptr_d[b];
      end
    end
  end

  // Response routing. Each requester arbitrates round-robin among banks
  // carrying its id, but only when its FIFO has room, so losing banks simply
  // hold. Responses whose id names no requester are drained lowest bank first.
  always_comb begin
    bank_rsp_ready_o = '0;
    drop_gnt         = '0;
    for (int b = N_BANKS - 1; b >= 0; b--) begin
      if (bank_rsp_valid_i[b] && (int'(bank_rsp_i[b*RSP_W +: SID_W]) >= N_REQS))
        drop_gnt = N_BANKS'(1) << b;
    end
    for (int r = 0; r < N_REQS; r++) begin
      full[r] = (cnt_q[r] == CNT_W'(RSP_DEPTH));
      for (int b = 0; b < N_BANKS; b++) begin
        rsp_match[r][b] = !full[r] && bank_rsp_valid_i[b] &&
                          (int'(bank_rsp_i[b*RSP_W +: SID_W]) == r);
        rsp_hi[r][b]    = rsp_match[r][b] && (b >= int'(rsp_ptr_q[r]));
      end
      rsp_sel[r] = (|rsp_hi[r]) ? rsp_hi[r] : rsp_match[r];
      rsp_gnt[r] = '0;
      for (int b = N_BANKS - 1; b >= 0; b--) begin
        if (rsp_sel[r][b]) rsp_gnt[r] = N_BANKS'(1) << b;
      end
      push_data[r] = '0;
      rsp_ptr_d[r] = rsp_ptr_q[r];
      for (int b = 0; b < N_BANKS; b++) begin
        if (rsp_gnt[r][b]) begin
          push_data[r] = bank_rsp_i[b*RSP_W +: RSP_W];
          rsp_ptr_d[r] = (b == N_BANKS - 1) ? '0 : BID_W'(b + 1);
        end
      end
      push[r] = |rsp_gnt[r];
      bank_rsp_ready_o = bank_rsp_ready_o | rsp_gnt[r];
    end
    bank_rsp_ready_o = bank_rsp_ready_o | drop_gnt;
  end

  // FIFO read side: head entry is presented whenever the FIFO is non-empty.
  always_comb begin
    core_rsp_o = '0;
    for (int r = 0; r < N_REQS; r++) begin
      core_rsp_valid_o[r] = (cnt_q[r] != '0);
      pop[r] = core_rsp_valid_o[r] & core_rsp_ready_i[r];
      core_rsp_o[r*RSP_W +: RSP_W] = mem[r][rptr_q[r]];
    end
  end

  // FIFO bookkeeping; full is taken from the count alone, so a pop in the
  // same cycle never makes room for a push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_sid_q <= 1'b0;
      for (int r = 0; r < N_REQS; r++) begin
        wptr_q[r]    <= '0;
        rptr_q[r]    <= '0;
        cnt_q[r]     <= '0;
        rsp_ptr_q[r] <= '0;
      end
    end else begin
      err_sid_q <= |drop_gnt;
      for (int r = 0; r < N_REQS; r++) begin
        if (push[r]) begin
          wptr_q[r]    <= wptr_q[r] + PTR_W'(1);
          rsp_ptr_q[r] <= rsp_ptr_d[r];
        end
        if (pop[r]) rptr_q[r] <= rptr_q[r] + PTR_W'(1);
        cnt_q[r] <= cnt_q[r] + CNT_W'(push[r]) - CNT_W'(pop[r]);
      end
    end
  end

  // FIFO storage has no reset; stale entries are hidden by the pointers.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < N_REQS; r++) begin
      if (rst_ni && push[r]) mem[r][wptr_q[r]] <= push_data[r];
    end
  end

  assign err_sid_o = err_sid_q;

endmodule

// File: tb/tb_hpdcache_bank_xbar_buf.sv
// ---------------------------------------------------------------------------
// tb_hpdcache_bank_xbar_buf
//
// Self-checking bench for hpdcache_bank_xbar_buf. A round-robin instance
// (N_REQS=4, N_BANKS=3 so bank id 3 is out of range) is fully checked; a
// fixed-priority instance shares the same inputs and has its request path
// checked. A cycle model written with cyclic-distance arithmetic and simple
// counters predicts every handshake; accepted requests and responses are
// queued, and a monitor pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_hpdcache_bank_xbar_buf;

  localparam int NR     = 4;
  localparam int NB     = 3;
  localparam int REQ_W  = 64;
  localparam int LATE_W = 40;
  localparam int RSP_W  = 72;
  localparam int SID_W  = 4;
  localparam int DEPTH  = 4;
  localparam int BID_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0]        core_req_valid_i;
  logic [NR-1:0]        core_req_ready_o, fp_core_req_ready_o;
  logic [NR*REQ_W-1:0]  core_req_i;
  logic [NR*BID_W-1:0]  core_req_bid_i;
  logic [NR-1:0]        core_req_abort_i;
  logic [NR*LATE_W-1:0] core_req_late_i;
  logic [NB-1:0]        bank_req_valid_o, fp_bank_req_valid_o;
  logic [NB-1:0]        bank_req_ready_i;
  logic [NB*REQ_W-1:0]  bank_req_o, fp_bank_req_o;
  logic [NB-1:0]        bank_abort_o, fp_bank_abort_o;
  logic [NB*LATE_W-1:0] bank_late_o, fp_bank_late_o;
  logic [NB-1:0]        bank_rsp_valid_i;
  logic [NB-1:0]        bank_rsp_ready_o, fp_bank_rsp_ready_o;
  logic [NB*RSP_W-1:0]  bank_rsp_i;
  logic [NR-1:0]        core_rsp_valid_o, fp_core_rsp_valid_o;
  logic [NR-1:0]        core_rsp_ready_i;
  logic [NR*RSP_W-1:0]  core_rsp_o, fp_core_rsp_o;
  logic                 err_sid_o, fp_err_sid_o;

  always #5 clk = ~clk;

  hpdcache_bank_xbar_buf #(
    .N_REQS(NR), .N_BANKS(NB), .REQ_W(REQ_W), .LATE_W(LATE_W), .RSP_W(RSP_W),
    .SID_W(SID_W), .ARB_RR(1), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_i(core_req_i), .core_req_bid_i(core_req_bid_i),
    .core_req_abort_i(core_req_abort_i), .core_req_late_i(core_req_late_i),
    .bank_req_valid_o(bank_req_valid_o), .bank_req_ready_i(bank_req_ready_i),
    .bank_req_o(bank_req_o), .bank_abort_o(bank_abort_o), .bank_late_o(bank_late_o),
    .bank_rsp_valid_i(bank_rsp_valid_i), .bank_rsp_ready_o(bank_rsp_ready_o),
    .bank_rsp_i(bank_rsp_i), .core_rsp_valid_o(core_rsp_valid_o),
    .core_rsp_ready_i(core_rsp_ready_i), .core_rsp_o(core_rsp_o),
    .err_sid_o(err_sid_o)
  );

  hpdcache_bank_xbar_buf #(
    .N_REQS(NR), .N_BANKS(NB), .REQ_W(REQ_W), .LATE_W(LATE_W), .RSP_W(RSP_W),
    .SID_W(SID_W), .ARB_RR(0), .RSP_DEPTH(DEPTH)
  ) dut_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(fp_core_req_ready_o),
    .core_req_i(core_req_i), .core_req_bid_i(core_req_bid_i),
    .core_req_abort_i(core_req_abort_i), .core_req_late_i(core_req_late_i),
    .bank_req_valid_o(fp_bank_req_valid_o), .bank_req_ready_i(bank_req_ready_i),
    .bank_req_o(fp_bank_req_o), .bank_abort_o(fp_bank_abort_o), .bank_late_o(fp_bank_late_o),
    .bank_rsp_valid_i(bank_rsp_valid_i), .bank_rsp_ready_o(fp_bank_rsp_ready_o),
    .bank_rsp_i(bank_rsp_i), .core_rsp_valid_o(fp_core_rsp_valid_o),
    .core_rsp_ready_i(core_rsp_ready_i), .core_rsp_o(fp_core_rsp_o),
    .err_sid_o(fp_err_sid_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // scoreboard queues
  logic [REQ_W-1:0] exp_req_q [NB][$];
  logic [RSP_W-1:0] exp_rsp_q [NR][$];

  // reference model state
  int rr_ptr_m  [NB];
  int prev_win  [NB];
  int rsp_ptr_m [NR];
  int fcnt      [NR];
  bit err_exp;
  bit rsp_acc   [NB];

  task automatic compareVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Cycle model: predicts outputs from the current inputs, checks them,
  // queues accepted traffic, then advances to the state after the edge.
  task automatic checkOutput();
    int win [NB];
    int fpwin [NB];
    int wb [NR];
    int drop, bid, sid, d, best;
    logic [NR-1:0] exp_rdy, exp_fp_rdy, exp_cvalid;
    logic [NB-1:0] exp_rrdy;
    exp_rdy = '0;
    exp_fp_rdy = '0;
    for (int b = 0; b < NB; b++) begin
      win[b] = -1;
      fpwin[b] = -1;
      best = NR;
      for (int r = 0; r < NR; r++) begin
        bid = int'(core_req_bid_i[r*BID_W +: BID_W]);
        if (core_req_valid_i[r] && bid == b) begin
          d = (r - rr_ptr_m[b] + NR) % NR;
          if (d < best) begin best = d; win[b] = r; end
          if (fpwin[b] < 0) fpwin[b] = r;
        end
      end
      compareVal($sformatf("bank_req_valid[%0d]", b), bank_req_valid_o[b], win[b] >= 0);
      if (win[b] >= 0)
        compareVal($sformatf("bank_req_data[%0d]", b), bank_req_o[b*REQ_W +: REQ_W],
                   core_req_i[win[b]*REQ_W +: REQ_W]);
      compareVal($sformatf("fp_bank_req_valid[%0d]", b), fp_bank_req_valid_o[b], fpwin[b] >= 0);
      if (fpwin[b] >= 0)
        compareVal($sformatf("fp_bank_req_data[%0d]", b), fp_bank_req_o[b*REQ_W +: REQ_W],
                   core_req_i[fpwin[b]*REQ_W +: REQ_W]);
      if (prev_win[b] >= 0) begin
        compareVal($sformatf("bank_abort[%0d]", b), bank_abort_o[b], core_req_abort_i[prev_win[b]]);
        compareVal($sformatf("bank_late[%0d]", b), bank_late_o[b*LATE_W +: LATE_W],
                   core_req_late_i[prev_win[b]*LATE_W +: LATE_W]);
      end else begin
        compareVal($sformatf("bank_abort_idle[%0d]", b), bank_abort_o[b], 1'b0);
      end
    end
    for (int r = 0; r < NR; r++) begin
      bid = int'(core_req_bid_i[r*BID_W +: BID_W]);
      if (bid < NB) begin
        exp_rdy[r]    = (win[bid] == r) && bank_req_ready_i[bid];
        exp_fp_rdy[r] = (fpwin[bid] == r) && bank_req_ready_i[bid];
      end
    end
    compareVal("core_req_ready", core_req_ready_o, exp_rdy);
    compareVal("fp_core_req_ready", fp_core_req_ready_o, exp_fp_rdy);

    drop = -1;
    exp_rrdy = '0;
    for (int b = 0; b < NB; b++) begin
      sid = int'(bank_rsp_i[b*RSP_W +: SID_W]);
      if (bank_rsp_valid_i[b] && sid >= NR && drop < 0) drop = b;
    end
    for (int r = 0; r < NR; r++) begin
      wb[r] = -1;
      exp_cvalid[r] = fcnt[r] > 0;
      if (fcnt[r] < DEPTH) begin
        best = NB;
        for (int b = 0; b < NB; b++) begin
          sid = int'(bank_rsp_i[b*RSP_W +: SID_W]);
          if (bank_rsp_valid_i[b] && sid == r) begin
            d = (b - rsp_ptr_m[r] + NB) % NB;
            if (d < best) begin best = d; wb[r] = b; end
          end
        end
      end
      if (wb[r] >= 0) exp_rrdy[wb[r]] = 1'b1;
    end
    if (drop >= 0) exp_rrdy[drop] = 1'b1;
    compareVal("bank_rsp_ready", bank_rsp_ready_o, exp_rrdy);
    compareVal("core_rsp_valid", core_rsp_valid_o, exp_cvalid);
    compareVal("err_sid", err_sid_o, err_exp);

    if (rst_ni) begin
      for (int b = 0; b < NB; b++) begin
        if (win[b] >= 0 && bank_req_ready_i[b]) begin
          exp_req_q[b].push_back(core_req_i[win[b]*REQ_W +: REQ_W]);
          rr_ptr_m[b] = (win[b] + 1) % NR;
          prev_win[b] = win[b];
        end else begin
          prev_win[b] = -1;
        end
        rsp_acc[b] = exp_rrdy[b];
      end
      for (int r = 0; r < NR; r++) begin
        if (fcnt[r] > 0 && core_rsp_ready_i[r]) fcnt[r]--;
        if (wb[r] >= 0) begin
          fcnt[r]++;
          exp_rsp_q[r].push_back(bank_rsp_i[wb[r]*RSP_W +: RSP_W]);
          rsp_ptr_m[r] = (wb[r] + 1) % NB;
        end
      end
      err_exp = drop >= 0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        rr_ptr_m[b] = 0; prev_win[b] = -1; rsp_acc[b] = 1'b0;
        exp_req_q[b].delete();
      end
      for (int r = 0; r < NR; r++) begin
        rsp_ptr_m[r] = 0; fcnt[r] = 0;
        exp_rsp_q[r].delete();
      end
      err_exp = 1'b0;
    end
  endtask

  // Advance one cycle: check at +3, then after the edge retire accepted
  // bank responses and refresh the second-cycle inputs.
  task automatic step();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) if (rsp_acc[b]) bank_rsp_valid_i[b] = 1'b0;
    core_req_abort_i = 4'($urandom);
    for (int r = 0; r < NR; r++) core_req_late_i[r*LATE_W +: LATE_W] = {8'($urandom), $urandom};
  endtask

  task automatic loadRsp(input int b, input int sid);
    logic [RSP_W-1:0] data;
    data = {8'($urandom), $urandom, $urandom};
    data[SID_W-1:0] = SID_W'(sid);
    bank_rsp_valid_i[b] = 1'b1;
    bank_rsp_i[b*RSP_W +: RSP_W] = data;
  endtask

  task automatic setReq(input int r, input int bid);
    core_req_valid_i[r] = 1'b1;
    core_req_bid_i[r*BID_W +: BID_W] = BID_W'(bid);
    core_req_i[r*REQ_W +: REQ_W] = {$urandom, $urandom};
  endtask

  task automatic applyStimulus();
    core_req_valid_i = 4'($urandom);
    core_req_bid_i   = 8'($urandom);
    for (int r = 0; r < NR; r++) core_req_i[r*REQ_W +: REQ_W] = {$urandom, $urandom};
    bank_req_ready_i = 3'($urandom) | 3'($urandom);
    for (int r = 0; r < NR; r++) core_rsp_ready_i[r] = ($urandom_range(9, 0) < 6);
    for (int b = 0; b < NB; b++) begin
      if (!bank_rsp_valid_i[b] && $urandom_range(2, 0) == 0)
        loadRsp(b, ($urandom_range(7, 0) == 0) ? int'($urandom_range(15, 4)) : int'($urandom_range(3, 0)));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_ni) begin
        for (int b = 0; b < NB; b++) begin
          if (bank_req_valid_o[b] && bank_req_ready_i[b]) begin
            compareVal($sformatf("req_expected[%0d]", b), exp_req_q[b].size() != 0, 1'b1);
            if (exp_req_q[b].size() != 0)
              compareVal($sformatf("req_sb[%0d]", b), bank_req_o[b*REQ_W +: REQ_W], exp_req_q[b].pop_front());
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (core_rsp_valid_o[r] && core_rsp_ready_i[r]) begin
            compareVal($sformatf("rsp_expected[%0d]", r), exp_rsp_q[r].size() != 0, 1'b1);
            if (exp_rsp_q[r].size() != 0)
              compareVal($sformatf("rsp_sb[%0d]", r), core_rsp_o[r*RSP_W +: RSP_W], exp_rsp_q[r].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int b = 0; b < NB; b++) begin rr_ptr_m[b] = 0; prev_win[b] = -1; rsp_acc[b] = 1'b0; end
    for (int r = 0; r < NR; r++) begin rsp_ptr_m[r] = 0; fcnt[r] = 0; end
    err_exp = 1'b0;
    rst_ni = 1'b0;
    core_req_valid_i = '0; core_req_i = '0; core_req_bid_i = '0;
    core_req_abort_i = '0; core_req_late_i = '0;
    bank_req_ready_i = '0; bank_rsp_valid_i = '0; bank_rsp_i = '0;
    core_rsp_ready_i = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step();
    step();
    rst_ni = 1'b1;
    step();

    $display("[TB] three requesters to bank 0");
    bank_req_ready_i = '1;
    setReq(0, 0); setReq(1, 0); setReq(2, 0);
    for (int i = 0; i < 3; i++) step();
    core_req_valid_i = '0;
    step();

    $display("[TB] stalled bank 1 with requester 3");
    setReq(3, 1);
    bank_req_ready_i = 3'b101;
    step();
    step();
    bank_req_ready_i = 3'b111;
    step();
    core_req_valid_i = '0;
    step();

    $display("[TB] simultaneous responses to requester 2");
    core_rsp_ready_i = '1;
    loadRsp(0, 2); loadRsp(1, 2);
    for (int i = 0; i < 4; i++) step();

    $display("[TB] requester 0 FIFO fill");
    core_rsp_ready_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      loadRsp(2, 0);
      for (int k = 0; k < 3 && bank_rsp_valid_i[2]; k++) step();
    end
    core_rsp_ready_i[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("[TB] out-of-range response id");
    loadRsp(0, 9);
    for (int i = 0; i < 3; i++) step();

    $display("[TB] reset with buffered responses");
    core_rsp_ready_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      loadRsp(1, 1);
      step();
    end
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    core_rsp_ready_i = '1;
    setReq(1, 0); setReq(3, 0);
    step();
    core_req_valid_i = '0;
    step();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      step();
    end

    core_req_valid_i = '0;
    core_rsp_ready_i = '1;
    bank_req_ready_i = '1;
    for (int i = 0; i < 30; i++) step();
    for (int r = 0; r < NR; r++)
      compareVal($sformatf("rsp_queue_drained[%0d]", r), exp_rsp_q[r].size(), 0);
    for (int b = 0; b < NB; b++)
      compareVal($sformatf("req_queue_drained[%0d]", b), exp_req_q[b].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_bank_xbar_buf.md
HPDCACHE_BANK_XBAR_BUF -- requirements
Module: hpdcache_bank_xbar_buf

Interface
REQ-001 SHALL take parameter N_REQS, default 4: number of requesters, range 1..16.
REQ-002 SHALL take parameter N_BANKS, default 2: number of banks, range 1..8.
REQ-003 SHALL take parameter REQ_W, default 64: request payload width.
REQ-004 SHALL take parameter LATE_W, default 40: second-cycle payload width (tag+PMA).
REQ-005 SHALL take parameter RSP_W, default 72: response payload width; bits [SID_W-1:0] carry the requester id.
REQ-006 SHALL take parameter SID_W, default 4: requester-id width, with 2^SID_W >= N_REQS.
REQ-007 SHALL take parameter ARB_RR, default 1: 1 selects round-robin request arbitration, 0 selects fixed priority with the lowest index first.
REQ-008 SHALL take parameter RSP_DEPTH, default 4: per-requester response FIFO depth, a power of two >= 2.
REQ-009 SHALL have port clk_i, input, 1: clock, rising edge.
REQ-010 SHALL have port rst_ni, input, 1: reset; synchronous, active-low.
REQ-011 SHALL have ports core_req_valid_i (input, N_REQS) and core_req_ready_o (output, N_REQS): request handshake.
REQ-012 SHALL have port core_req_i, input, N_REQS*REQ_W: request payloads.
REQ-013 SHALL have port core_req_bid_i, input, N_REQS*max(1,$clog2(N_BANKS)): target bank per requester.
REQ-014 SHALL have ports core_req_abort_i (input, N_REQS) and core_req_late_i (input, N_REQS*LATE_W): second-cycle inputs.
REQ-015 SHALL have ports bank_req_valid_o (output, N_BANKS), bank_req_ready_i (input, N_BANKS) and bank_req_o (output, N_BANKS*REQ_W): bank request path.
REQ-016 SHALL have ports bank_abort_o (output, N_BANKS) and bank_late_o (output, N_BANKS*LATE_W): second-cycle bank outputs.
REQ-017 SHALL have ports bank_rsp_valid_i (input, N_BANKS), bank_rsp_ready_o (output, N_BANKS) and bank_rsp_i (input, N_BANKS*RSP_W): bank response path.
REQ-018 SHALL have ports core_rsp_valid_o (output, N_REQS), core_rsp_ready_i (input, N_REQS) and core_rsp_o (output, N_REQS*RSP_W): requester response path.
REQ-019 SHALL have port err_sid_o, output, 1: one-cycle pulse when a response with an out-of-range SID is dropped.

Function
REQ-020 SHALL, per bank, select one-hot gnt among requesters with valid and a bid equal to that bank, combinationally in the same cycle.
REQ-021 SHALL drive bank_req_valid_o = |gnt, bank_req_o = payload of the granted requester, and core_req_ready_o[r] = bank_req_ready_i[bid(r)] & gnt[bid(r)][r].
REQ-022 SHALL, when a bid is >= N_BANKS, grant the request to no bank and hold core_req_ready_o[r] = 0.
REQ-023 SHALL, with ARB_RR=1, move the per-bank priority pointer to one past the winner only on an accepted handshake (valid & ready); a stalled grant SHALL remain stable with an unchanged pointer.
REQ-024 SHALL register gnt_q[b] = gnt[b] when bank b accepts a request, else 0; bank_abort_o and bank_late_o SHALL be muxed by gnt_q one cycle after acceptance, and bank_abort_o SHALL be 0 when gnt_q is 0.
REQ-025 SHALL, per requester, round-robin arbitrate among banks whose bank_rsp_valid_i is set with SID equal to the requester index, granting only when that requester's FIFO is not full.
REQ-026 SHALL assert bank_rsp_ready_o[b] only when bank b is granted by its target requester's arbiter; losing banks SHALL hold their responses (no loss on simultaneous responses).
REQ-027 SHALL, for SID >= N_REQS, assert bank_rsp_ready_o (drop the response), with the lowest such bank first, and pulse err_sid_o the following cycle.
REQ-028 SHALL make each FIFO 1-cycle latency (push at cycle N, visible at N+1), drive core_rsp_valid_o = !empty from the head entry, and pop on valid & ready.
REQ-029 SHALL compute FIFO full from the occupancy only, so a push is refused when full even when a pop occurs in the same cycle; push and pop together at non-full, non-empty SHALL leave the count unchanged.
REQ-030 SHALL wrap the read/write pointers modulo RSP_DEPTH and keep the count in $clog2(RSP_DEPTH)+1 bits.

Reset
REQ-031 SHALL, on a rising edge with rst_ni=0, clear gnt_q, the RR pointers (to index 0), the FIFO pointers and counts, and err_sid_o; core_rsp_valid_o and bank_abort_o SHALL be 0 the next cycle, with in-flight FIFO data discarded.
REQ-032 SHALL keep the combinational request outputs functional during reset, but no accepted request SHALL update state while rst_ni=0.

Verification
REQ-033 SHALL cover: requesters 0, 1 and 2 all to bank 0, ready=1, ARB_RR=1, for 3 cycles -> grants in order 0, 1, 2; ARB_RR=0 -> 0, 0, 0.
REQ-034 SHALL cover: bank 1 ready=0 for 2 cycles with requester 3 valid -> bank_req_valid_o[1]=1, payload stable, ready_o[3]=0; the release is accepted and bank_late_o[1] equals late_i[3] in the next cycle.
REQ-035 SHALL cover: banks 0 and 1 responding to SID 2 in the same cycle -> one accepted, the other held; core_rsp_o[2] delivers both in consecutive cycles.
REQ-036 SHALL cover: core_rsp_ready_i[0]=0 with 5 responses to SID 0 and RSP_DEPTH=4 -> 4 buffered, the fifth's bank_rsp_ready_o=0 until the first pop.
REQ-037 SHALL cover: a response with SID=9 and N_REQS=4 -> ready=1, no core_rsp_valid_o, err_sid_o=1 for exactly one cycle.
REQ-038 SHALL cover: rst_ni=0 with 3 entries in FIFO 1 -> core_rsp_valid_o[1]=0 the next cycle and the RR pointer restarts at requester 0.
